// File: rtl/dispensador_pkg.sv
// Shared types and constants for the change/product dispenser.
package dispensador_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRODUCT   = 3'd1,
    ST_HOPPER    = 3'd2,
    ST_WAIT_COIN = 3'd3,
    ST_GAP       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_10   = 2'd1;
  localparam logic [1:0] CODE_20   = 2'd2;
  localparam logic [1:0] CODE_RSVD = 2'd3;

  // One queued dispense request: product release flag plus coins to pay out.
  typedef struct packed {
    logic       vend;
    logic [1:0] coins;
  } entry_t;

endpackage

// File: rtl/dispensador_cambio_sincronizador.sv
// Two-flop synchronizer for an asynchronous optical sensor, followed by a
// rising-edge detector on the synchronized level.
module sincronizador_flanco (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  // sync_q[0..1] form the synchronizer, sync_q[2] holds the previous level.
  logic [2:0] sync_q;

  // Shift the sensor level through the synchronizer chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 3'b000;
    else     sync_q <= {sync_q[1:0], async_in};
  end

  assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/dispensador_cambio.sv
// Actuator-side dispenser: buffers vend/change requests in a 2-entry FIFO and
// sequences the product motor and the 10-peso coin hopper, confirming every
// action with a synchronized optical sensor edge.
//
// Handshake: a request is offered whenever vend | (change_code != 0) in a
// cycle; it is taken when the queue has room or is popped that same cycle,
// otherwise it is dropped and overrun latches. There is no back-pressure.
module dispensador_cambio
  import dispensador_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend,
  input  logic [1:0] change_code,
  input  logic       product_sense,
  input  logic       coin_sense,
  output logic       motor_on,
  output logic       hopper_pulse,
  output logic       busy,
  output logic       full,
  output logic       overrun,
  output logic       bad_code,
  output logic       fault
);

  localparam int unsigned MAX_AB  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(PULSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_next;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         coins_a;
  logic               coin_hit;
  logic               product_rise, coin_rise;
  logic               pop, coin_dec;

  entry_t     q_mem [2];
  logic       q_wr, q_rd;
  logic [1:0] q_count;
  entry_t     req_entry, head;
  logic       req_valid, push;

  sincronizador_flanco u_sync_product (
    .clk      (clk),
    .rst      (rst),
    .async_in (product_sense),
    .rise     (product_rise)
  );

  sincronizador_flanco u_sync_coin (
    .clk      (clk),
    .rst      (rst),
    .async_in (coin_sense),
    .rise     (coin_rise)
  );

  // Reserved code 3 still dispenses the product (if any) but no coins.
  assign req_valid       = vend | (change_code != CODE_NONE);
  assign req_entry.vend  = vend;
  assign req_entry.coins = (change_code == CODE_RSVD) ? 2'd0 : change_code;
  assign full            = (q_count == 2'd2);
  assign push            = req_valid & (~full | pop);
  assign head            = q_mem[q_rd];
  assign busy            = (state != ST_IDLE) | (q_count != 2'd0);
  assign fault           = (state == ST_FAULT);

  // Queue storage: no reset needed, occupancy is tracked by q_count.
  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr] <= req_entry;
  end

  // Queue pointers and occupancy; pop and push may coincide even when full.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr    <= 1'b0;
      q_rd    <= 1'b0;
      q_count <= 2'd0;
    end else begin
      if (push) q_wr <= ~q_wr;
      if (pop)  q_rd <= ~q_rd;
      q_count <= q_count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun  <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      if (req_valid && full && !pop)    overrun  <= 1'b1;
      if (change_code == CODE_RSVD)     bad_code <= 1'b1;
    end
  end

  // State, timer, active coin count and early-coin latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      timer    <= '0;
      coins_a  <= 2'd0;
      coin_hit <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)  timer <= '0;
      else if (timer != '1)     timer <= timer + 1'b1;
      if (pop)                  coins_a <= head.coins;
      else if (coin_dec)        coins_a <= coins_a - 2'd1;
      if (coin_dec)                                            coin_hit <= 1'b0;
      else if (state == ST_HOPPER && coin_rise)                coin_hit <= 1'b1;
      else if (state != ST_HOPPER && state != ST_WAIT_COIN)    coin_hit <= 1'b0;
    end
  end

  // Next-state and actuator decode.
  always_comb begin
    state_next   = state;
    pop          = 1'b0;
    coin_dec     = 1'b0;
    motor_on     = 1'b0;
    hopper_pulse = 1'b0;
    case (state)
      ST_IDLE: begin
        if (q_count != 2'd0) begin
          pop = 1'b1;
          if (head.vend)               state_next = ST_PRODUCT;
          else if (head.coins != 2'd0) state_next = ST_HOPPER;
        end
      end
      ST_PRODUCT: begin
        motor_on = 1'b1;
        if (product_rise)               state_next = (coins_a != 2'd0) ? ST_HOPPER : ST_IDLE;
        else if (timer == TIMEOUT_LAST) state_next = ST_FAULT;
      end
      ST_HOPPER: begin
        hopper_pulse = 1'b1;
        if (timer == PULSE_LAST) state_next = ST_WAIT_COIN;
      end
      ST_WAIT_COIN: begin
        if (coin_rise || coin_hit) begin
          coin_dec   = 1'b1;
          state_next = ST_GAP;
        end else if (timer == TIMEOUT_LAST) begin
          state_next = ST_FAULT;
        end
      end
      ST_GAP: begin
        if (timer == GAP_LAST) state_next = (coins_a != 2'd0) ? ST_HOPPER : ST_IDLE;
      end
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dispensador_cambio.sv
// Directed bench for dispensador_cambio with a reactive mechanics model and
// an actuation-event scoreboard.
module tb_dispensador_cambio;

  localparam int PULSE   = 4;
  localparam int TIMEOUT = 16;
  localparam logic [1:0] EV_NONE  = 2'd0;
  localparam logic [1:0] EV_MOTOR = 2'd1;
  localparam logic [1:0] EV_COIN  = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vend = 1'b0;
  logic [1:0] change_code = 2'd0;
  logic       product_sense = 1'b0;
  logic       coin_sense = 1'b0;
  logic       motor_on, hopper_pulse, busy, full, overrun, bad_code, fault;

  logic       mech_en = 1'b1;
  logic [1:0] exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  dispensador_cambio #(.PULSE_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .vend          (vend),
    .change_code   (change_code),
    .product_sense (product_sense),
    .coin_sense    (coin_sense),
    .motor_on      (motor_on),
    .hopper_pulse  (hopper_pulse),
    .busy          (busy),
    .full          (full),
    .overrun       (overrun),
    .bad_code      (bad_code),
    .fault         (fault)
  );

  // Clock and global watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for one cycle; queue its actuations if it should run.
  task automatic req(input logic v, input logic [1:0] c, input logic runs);
    if (runs) begin
      if (v) exp_q.push_back(EV_MOTOR);
      if (c == 2'd1 || c == 2'd2)
        for (int i = 0; i < int'(c); i++) exp_q.push_back(EV_COIN);
    end
    vend        = v;
    change_code = c;
    step();
    vend        = 1'b0;
    change_code = 2'd0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy !== 1'b0; i++) step();
    check(tag, busy, 0);
    repeat (4) step();
  endtask

  // Mechanics model: product passes the sensor a few cycles after the motor
  // starts, a coin passes shortly after each solenoid pulse begins.
  always begin
    @(negedge clk);
    if (mech_en && motor_on === 1'b1) begin
      repeat (3) @(negedge clk);
      product_sense = 1'b1;
      repeat (2) @(negedge clk);
      product_sense = 1'b0;
    end else if (mech_en && hopper_pulse === 1'b1) begin
      repeat (2) @(negedge clk);
      coin_sense = 1'b1;
      repeat (2) @(negedge clk);
      coin_sense = 1'b0;
    end
  end

  // Scoreboard monitor: every actuation start pops the expected queue;
  // every completed hopper pulse must be PULSE cycles wide.
  logic prev_m = 1'b0, prev_h = 1'b0, hw_abort = 1'b0;
  int   hw = 0;
  always @(negedge clk) begin
    logic [1:0] obs_ev, exp_ev;
    obs_ev = EV_NONE;
    if (motor_on === 1'b1 && prev_m !== 1'b1)     obs_ev = EV_MOTOR;
    if (hopper_pulse === 1'b1 && prev_h !== 1'b1) obs_ev = EV_COIN;
    if (obs_ev != EV_NONE) begin
      exp_ev = (exp_q.size() > 0) ? exp_q.pop_front() : EV_NONE;
      check("actuation event", obs_ev, exp_ev);
    end
    if (hopper_pulse === 1'b1) begin
      hw++;
      if (rst === 1'b1) hw_abort = 1'b1;
    end else if (prev_h === 1'b1) begin
      if (!hw_abort) check("hopper pulse width", hw, PULSE);
      hw       = 0;
      hw_abort = 1'b0;
    end
    prev_m = motor_on;
    prev_h = hopper_pulse;
  end

  initial begin
    // Reset state.
    repeat (2) step();
    check("rst motor_on", motor_on, 0);
    check("rst hopper_pulse", hopper_pulse, 0);
    check("rst busy", busy, 0);
    check("rst full", full, 0);
    check("rst overrun", overrun, 0);
    check("rst bad_code", bad_code, 0);
    check("rst fault", fault, 0);
    rst = 1'b0;
    step();

    // Product plus two coins: motor one cycle after capture.
    req(1'b1, 2'd2, 1'b1);
    check("A captured busy", busy, 1);
    check("A motor not yet", motor_on, 0);
    step();
    check("A motor latency", motor_on, 1);
    wait_idle("A idle");

    // One coin, no product.
    req(1'b0, 2'd1, 1'b1);
    check("B motor off", motor_on, 0);
    wait_idle("B idle");

    // Reserved code: flag only, empty entry consumed.
    req(1'b0, 2'd3, 1'b1);
    check("C bad_code", bad_code, 1);
    check("C busy queued", busy, 1);
    step();
    check("C busy drained", busy, 0);
    check("C hopper idle", hopper_pulse, 0);

    // Three requests while the motor runs: two queued, third dropped.
    req(1'b1, 2'd0, 1'b1);
    step();
    check("D motor on", motor_on, 1);
    req(1'b1, 2'd1, 1'b1);
    req(1'b0, 2'd2, 1'b1);
    check("D full", full, 1);
    check("D no overrun yet", overrun, 0);
    req(1'b1, 2'd0, 1'b0);
    check("D overrun", overrun, 1);
    wait_idle("D idle");
    check("D bad_code sticky", bad_code, 1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2 overrun", overrun, 0);
    check("rst2 bad_code", bad_code, 0);

    // Full queue with pop and write in the same cycle.
    req(1'b1, 2'd0, 1'b1);
    step();
    check("F motor on", motor_on, 1);
    req(1'b1, 2'd0, 1'b1);
    req(1'b1, 2'd0, 1'b1);
    check("F full", full, 1);
    for (int i = 0; i < 40 && motor_on === 1'b1; i++) step();
    check("F motor done", motor_on, 0);
    check("F still full", full, 1);
    req(1'b0, 2'd1, 1'b1);
    check("F full after pop+write", full, 1);
    check("F overrun clear", overrun, 0);
    wait_idle("F idle");

    // Product sensor never fires: timeout to fault.
    mech_en = 1'b0;
    req(1'b1, 2'd0, 1'b1);
    step();
    check("E motor on", motor_on, 1);
    repeat (TIMEOUT - 1) step();
    check("E fault not yet", fault, 0);
    check("E motor still on", motor_on, 1);
    step();
    check("E fault", fault, 1);
    check("E motor off", motor_on, 0);
    mech_en = 1'b1;
    req(1'b1, 2'd1, 1'b0);
    req(1'b0, 2'd2, 1'b0);
    check("E queue fills", full, 1);
    repeat (10) step();
    check("E fault sticky", fault, 1);
    check("E no motor", motor_on, 0);
    check("E no hopper", hopper_pulse, 0);

    // Reset during HOPPER discards everything; fresh request runs.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("G fault cleared", fault, 0);
    check("G full cleared", full, 0);
    req(1'b0, 2'd1, 1'b1);
    req(1'b0, 2'd1, 1'b0);
    for (int i = 0; i < 20 && hopper_pulse !== 1'b1; i++) step();
    check("G hopper started", hopper_pulse, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("G hopper dropped", hopper_pulse, 0);
    check("G busy cleared", busy, 0);
    check("G full cleared2", full, 0);
    check("G overrun cleared", overrun, 0);
    repeat (8) step();
    check("G stays idle", busy, 0);
    req(1'b1, 2'd2, 1'b1);
    wait_idle("G idle");

    check("events outstanding", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dispensador_cambio.md
Name: dispensador_cambio

Overview:
- Actuator-side counterpart of the coin-acceptance FSM in the vending design.
- Consumes the FSM's one-cycle dispense request (vend strobe plus change code, where 1 means 10 pesos and 2 means 20 pesos).
- Drives the product motor and the 10-peso coin hopper solenoid; each action is confirmed by an optical sensor.
- Requests are buffered in a 2-entry queue, so back-to-back sales are never lost while the mechanics are busy.

Parameters:
- PULSE_CYCLES, 4: hopper solenoid pulse width in clk cycles (>=1).
- GAP_CYCLES, 2: idle cycles after each confirmed coin before the next pulse (>=1).
- TIMEOUT_CYCLES, 16: max cycles to wait for a sensor confirmation before faulting (>=4).

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- vend, input, 1: request product release; sampled every cycle.
- change_code, input, 2: 0 none, 1 one coin, 2 two coins, 3 reserved.
- product_sense, input, 1: asynchronous optical sensor, high while product passes.
- coin_sense, input, 1: asynchronous optical sensor, high while coin passes.
- motor_on, output, 1: product motor enable.
- hopper_pulse, output, 1: coin solenoid drive.
- busy, output, 1: FSM not in IDLE, or queue non-empty.
- full, output, 1: queue holds 2 entries.
- overrun, output, 1: sticky; a request arrived while full.
- bad_code, output, 1: sticky; change_code==3 was received.
- fault, output, 1: sticky; sensor timeout occurred.

Behaviour:
- Reset: every output 0, queue empty, FSM in IDLE, counters 0, sticky flags cleared. Reset mid-operation aborts immediately; motor and hopper drop on the next edge; queued entries are discarded.
- Request valid: vend | (change_code != 0). A valid request is written as {vend, coins}. coins = change_code, except code 3 stores 0 coins and sets bad_code.
- Queue: 2-entry FIFO with 3-bit entries.
  - Write when valid and not full.
  - Valid while full: request dropped, overrun set, queue unchanged.
  - Pop occurs when IDLE loads an entry. Pop and write in the same cycle are allowed even when full, so a write while full is accepted if a pop happens that cycle.
- Sensors: each passes through a 2-flop synchronizer, then rising-edge detection. Confirmation means a synchronized rising edge.
- FSM states: IDLE, PRODUCT, HOPPER, WAIT_COIN, GAP, FAULT.
  - IDLE: if queue non-empty, pop the entry into the active registers (vend_a, coins_a). If vend_a, go to PRODUCT; else if coins_a > 0, go to HOPPER; else stay in IDLE (empty entry consumed).
  - PRODUCT: motor_on=1 and the timer counts.
    - Product edge: go to HOPPER if coins_a > 0, else IDLE.
    - Timer reaches TIMEOUT_CYCLES: go to FAULT.
  - HOPPER: hopper_pulse=1 for exactly PULSE_CYCLES cycles, then go to WAIT_COIN with the timer cleared.
  - WAIT_COIN: a coin edge decrements coins_a, then go to GAP. The timer reaching TIMEOUT_CYCLES goes to FAULT. A coin edge that arrives during HOPPER is also accepted as the confirmation.
  - GAP: GAP_CYCLES idle cycles, then HOPPER if coins_a > 0, else IDLE.
  - FAULT: motor_on=0, hopper_pulse=0, fault=1. Remains until rst. The queue still accepts requests until full; none are executed.
- Latency: request sampled at edge k, entry popped at edge k+1, motor_on (or hopper_pulse) high from edge k+1. Output is 1 cycle after capture when the FSM is idle and the queue is empty.
- Timer width is $clog2(max(PULSE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1). The timer is cleared on every state entry and saturates; it never wraps.
- Sensor edges in IDLE, GAP or FAULT are ignored.

Decomposition:
- Package dispensador_pkg holds:
  - state enum typedef (3 bits);
  - change-code constants CODE_NONE/CODE_10/CODE_20/CODE_RSVD;
  - entry struct {vend, coins[1:0]}.
- Sub-module sincronizador_flanco: 2-flop synchronizer plus rising-edge detector. Instantiated twice, once for product_sense and once for coin_sense.

Test Plan:
- vend=1, code=2 at cycle 0:
  - motor_on=1 from cycle 1.
  - product_sense pulse at cycle 4: motor_on=0 after edge detect, then hopper_pulse high 4 cycles.
  - Each coin_sense returns: two hopper pulses separated by GAP, then busy=0.
- code=1 with no vend: no motor_on; single 4-cycle hopper_pulse; coin confirmed; IDLE. Code 3: bad_code=1, no actuation, queue returns empty.
- Three requests on consecutive cycles while busy with product: first two accepted (full=1), third dropped (overrun=1); the accepted ones execute in order.
- vend with product_sense held low: fault=1 exactly TIMEOUT_CYCLES cycles after motor_on rises; motor_on=0; later requests never actuate until rst.
- rst asserted during HOPPER: hopper_pulse=0, all flags 0, queue empty after that edge; a fresh request then runs normally.
- Full queue with pop and write in the same cycle: write accepted, overrun stays 0.
